spi_txn_arbiter: RTL and testbench

- Shares one SPI_4 master between NREQ requesters (SD-card driver, sensor poller, debug port, ...); arbitration is round-robin.
- Loads the winner's transaction configuration onto the master and waits out the master's mode-change clock settle.
- Drives the spi_start handshake, then waits for completion or timeout, and returns a per-requester done/error pulse.
- Sits between the requester logic and the SPI master. It owns the master's spi_start, rst and configuration inputs.

---
 rtl/spi_txn_arbiter.sv | 277 +++++++++++++++++++++++++++
 tb/tb_spi_txn_arbiter.sv | 369 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/spi_txn_arbiter.sv
// ---------------------------------------------------------------------------
// spi_txn_arbiter
//
// Shares a single SPI master between NREQ requesters using round-robin
// arbitration. The winner's configuration is latched onto the master's
// configuration inputs, held for SETTLE_CYCLES so the master's clock/mode
// change can settle, and then the spi_start handshake is run. The arbiter
// then waits for completion (busy low with valid high) or for a timeout. On
// a timeout it pulses the master's reset for 4 cycles. Either way the owner
// receives a one-cycle done pulse, and err is added on a timeout.
//
// Ports
//   clk                      system clock
//   rst_n                    asynchronous active-low reset
//   req[NREQ]                per-requester transaction request (level)
//   cfg_flat[NREQ*CFG_W]     packed configs, requester i at [i*CFG_W +: CFG_W]
//   grant[NREQ]              one-hot current owner of the master
//   done[NREQ]               one-cycle end-of-transaction pulse to the owner
//   err                      coincident with done when the transaction timed out
//   spi_start / spi_rst      master handshake start / master reset (active-high)
//   spi_clk_ss .. spi_receive_data_length
//                            registered configuration driven to the master
//   busy_spi / valid_spi     status from the master
//   arb_busy                 high whenever the arbiter is not idle
// ---------------------------------------------------------------------------
module spi_txn_arbiter #(
    parameter int NREQ           = 4,
    parameter int CFG_W          = 35,
    parameter int SETTLE_CYCLES  = 256,
    parameter int TIMEOUT_CYCLES = 2000000,
    parameter int TO_W           = 21
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [NREQ-1:0]       req,
    input  logic [NREQ*CFG_W-1:0] cfg_flat,
    output logic [NREQ-1:0]       grant,
    output logic [NREQ-1:0]       done,
    output logic                  err,
    output logic                  spi_start,
    output logic                  spi_rst,
    output logic                  spi_clk_ss,
    output logic [1:0]            spi_mode,
    output logic [5:0]            spi_cmd_length,
    output logic [9:0]            spi_send_data_length,
    output logic [5:0]            spi_response_length,
    output logic [9:0]            spi_receive_data_length,
    input  logic                  busy_spi,
    input  logic                  valid_spi,
    output logic                  arb_busy
);

    localparam int PTR_W = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam int SET_W = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;

    localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(NREQ - 1);
    localparam logic [SET_W-1:0] SET_LAST = SET_W'(SETTLE_CYCLES - 1);
    localparam logic [TO_W-1:0]  TO_LAST  = TO_W'(TIMEOUT_CYCLES - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_SETUP,
        S_START,
        S_RUN,
        S_FINISH,
        S_RECOVER
    } state_t;

    // State and registered outputs
    state_t             r_state;
    logic [PTR_W-1:0]   r_ptr;
    logic [PTR_W-1:0]   r_owner;
    logic [NREQ-1:0]    r_grant;
    logic [NREQ-1:0]    r_done;
    logic               r_err;
    logic               r_start;
    logic               r_rst;
    logic [CFG_W-1:0]   r_cfg;
    logic [SET_W-1:0]   r_set_cnt;
    logic [TO_W-1:0]    r_to_cnt;
    logic [1:0]         r_rec_cnt;

    // Next-state values
    state_t             w_state;
    logic [PTR_W-1:0]   w_ptr;
    logic [PTR_W-1:0]   w_owner;
    logic [NREQ-1:0]    w_grant;
    logic [NREQ-1:0]    w_done;
    logic               w_err;
    logic               w_start;
    logic               w_rst;
    logic [CFG_W-1:0]   w_cfg;
    logic [SET_W-1:0]   w_set_cnt;
    logic [TO_W-1:0]    w_to_cnt;
    logic [1:0]         w_rec_cnt;

    // Arbitration results
    logic [PTR_W-1:0]   w_hi_win;
    logic [PTR_W-1:0]   w_lo_win;
    logic               w_hi_any;
    logic [PTR_W-1:0]   w_win;
    logic [NREQ-1:0]    w_win_oh;
    logic [CFG_W-1:0]   w_cfg_sel;
    logic [PTR_W-1:0]   w_ptr_adv;

    // Round-robin pick: lowest set request at or above the pointer; if there
    // is none, wrap around to the lowest set request overall. The loop runs
    // downward so the last hit is the lowest index.
    always_comb begin
        w_hi_win = '0;
        w_lo_win = '0;
        w_hi_any = 1'b0;
        for (int i = NREQ - 1; i >= 0; i--) begin
            if (req[i]) begin
                w_lo_win = PTR_W'(i);
                if (i >= int'(r_ptr)) begin
                    w_hi_win = PTR_W'(i);
                    w_hi_any = 1'b1;
                end
            end
        end
        w_win = w_hi_any ? w_hi_win : w_lo_win;
    end

    always_comb begin
        w_win_oh  = '0;
        w_cfg_sel = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (w_win == PTR_W'(i)) begin
                w_win_oh[i] = 1'b1;
                w_cfg_sel   = cfg_flat[i*CFG_W +: CFG_W];
            end
        end
    end

    assign w_ptr_adv = (r_owner == PTR_LAST) ? '0 : r_owner + PTR_W'(1);

    // Next-state and output logic
    always_comb begin
        w_state   = r_state;
        w_ptr     = r_ptr;
        w_owner   = r_owner;
        w_grant   = r_grant;
        w_done    = '0;
        w_err     = 1'b0;
        w_start   = r_start;
        w_rst     = r_rst;
        w_cfg     = r_cfg;
        w_set_cnt = r_set_cnt;
        w_to_cnt  = r_to_cnt;
        w_rec_cnt = r_rec_cnt;

        case (r_state)
            S_IDLE: begin
                // The configuration register is only loaded here, so the
                // master sees a stable config for the whole transaction.
                if (|req) begin
                    w_grant   = w_win_oh;
                    w_owner   = w_win;
                    w_cfg     = w_cfg_sel;
                    w_set_cnt = '0;
                    w_state   = S_SETUP;
                end
            end

            S_SETUP: begin
                if (r_set_cnt == SET_LAST) begin
                    w_to_cnt = '0;
                    w_start  = 1'b1;
                    w_state  = S_START;
                end else begin
                    w_set_cnt = r_set_cnt + SET_W'(1);
                end
            end

            S_START: begin
                if (r_to_cnt == TO_LAST) begin
                    w_start   = 1'b0;
                    w_rst     = 1'b1;
                    w_rec_cnt = '0;
                    w_state   = S_RECOVER;
                end else begin
                    w_to_cnt = r_to_cnt + TO_W'(1);
                    if (busy_spi) begin
                        w_start = 1'b0;
                        w_state = S_RUN;
                    end
                end
            end

            S_RUN: begin
                // A completion seen on the final timeout cycle still counts
                // as a clean finish; the master needs no reset then.
                if (!busy_spi && valid_spi) begin
                    w_done  = r_grant;
                    w_state = S_FINISH;
                end else if (r_to_cnt == TO_LAST) begin
                    w_rst     = 1'b1;
                    w_rec_cnt = '0;
                    w_state   = S_RECOVER;
                end else begin
                    w_to_cnt = r_to_cnt + TO_W'(1);
                end
            end

            S_RECOVER: begin
                if (r_rec_cnt == 2'd3) begin
                    w_rst   = 1'b0;
                    w_done  = r_grant;
                    w_err   = 1'b1;
                    w_state = S_FINISH;
                end else begin
                    w_rec_cnt = r_rec_cnt + 2'd1;
                end
            end

            S_FINISH: begin
                // done (registered on entry) and grant fall on the same edge.
                w_grant = '0;
                w_ptr   = w_ptr_adv;
                w_state = S_IDLE;
            end

            default: begin
                w_state = S_IDLE;
                w_grant = '0;
                w_start = 1'b0;
                w_rst   = 1'b0;
            end
        endcase
    end

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= S_IDLE;
            r_ptr     <= '0;
            r_owner   <= '0;
            r_grant   <= '0;
            r_done    <= '0;
            r_err     <= 1'b0;
            r_start   <= 1'b0;
            r_rst     <= 1'b0;
            r_cfg     <= '0;
            r_set_cnt <= '0;
            r_to_cnt  <= '0;
            r_rec_cnt <= '0;
        end else begin
            r_state   <= w_state;
            r_ptr     <= w_ptr;
            r_owner   <= w_owner;
            r_grant   <= w_grant;
            r_done    <= w_done;
            r_err     <= w_err;
            r_start   <= w_start;
            r_rst     <= w_rst;
            r_cfg     <= w_cfg;
            r_set_cnt <= w_set_cnt;
            r_to_cnt  <= w_to_cnt;
            r_rec_cnt <= w_rec_cnt;
        end
    end

    assign grant                   = r_grant;
    assign done                    = r_done;
    assign err                     = r_err;
    assign spi_start               = r_start;
    assign spi_rst                 = r_rst;
    assign spi_clk_ss              = r_cfg[34];
    assign spi_mode                = r_cfg[33:32];
    assign spi_cmd_length          = r_cfg[31:26];
    assign spi_send_data_length    = r_cfg[25:16];
    assign spi_response_length     = r_cfg[15:10];
    assign spi_receive_data_length = r_cfg[9:0];
    assign arb_busy                = (r_state != S_IDLE);

endmodule

// File: tb/tb_spi_txn_arbiter.sv
// ---------------------------------------------------------------------------
// tb_spi_txn_arbiter
//
// Self-checking bench for spi_txn_arbiter (NREQ=4, short settle/timeout).
// A vector table drives single transactions with hand-derived owners; hand
// sequences cover round-robin, starvation, config isolation and async reset.
// A scoreboard queue holds the expected {owner, err} of each done pulse.
// ---------------------------------------------------------------------------
module tb_spi_txn_arbiter;

    localparam int NREQ     = 4;
    localparam int CFG_W    = 35;
    localparam int SETTLE   = 32;
    localparam int TIMEOUT  = 100;
    localparam int WAIT_MAX = 500;

    localparam int W_GRANT = 0;
    localparam int W_NOGNT = 1;
    localparam int W_DONE  = 2;
    localparam int W_START = 3;
    localparam int W_NOSTA = 4;
    localparam int W_IDLE  = 5;

    logic                  clk;
    logic                  rst_n;
    logic [NREQ-1:0]       req;
    logic [NREQ*CFG_W-1:0] cfg_flat;
    logic [NREQ-1:0]       grant;
    logic [NREQ-1:0]       done;
    logic                  err;
    logic                  spi_start;
    logic                  spi_rst;
    logic                  spi_clk_ss;
    logic [1:0]            spi_mode;
    logic [5:0]            spi_cmd_length;
    logic [9:0]            spi_send_data_length;
    logic [5:0]            spi_response_length;
    logic [9:0]            spi_receive_data_length;
    logic                  busy_spi;
    logic                  valid_spi;
    logic                  arb_busy;

    spi_txn_arbiter #(
        .NREQ(NREQ), .CFG_W(CFG_W), .SETTLE_CYCLES(SETTLE),
        .TIMEOUT_CYCLES(TIMEOUT), .TO_W(7)
    ) dut (
        .clk(clk), .rst_n(rst_n), .req(req), .cfg_flat(cfg_flat),
        .grant(grant), .done(done), .err(err),
        .spi_start(spi_start), .spi_rst(spi_rst),
        .spi_clk_ss(spi_clk_ss), .spi_mode(spi_mode),
        .spi_cmd_length(spi_cmd_length),
        .spi_send_data_length(spi_send_data_length),
        .spi_response_length(spi_response_length),
        .spi_receive_data_length(spi_receive_data_length),
        .busy_spi(busy_spi), .valid_spi(valid_spi), .arb_busy(arb_busy)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    typedef struct {
        logic [3:0] req;
        int         owner;
        logic       err;
        logic       hang;
    } vec_t;

    typedef struct {
        int   owner;
        logic err;
    } sb_t;

    int         checks   = 0;
    int         failures = 0;
    sb_t        sb_q[$];
    vec_t       vecs[9];
    logic [34:0] cfg_tbl[4];
    logic       hang;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [3:0] oh(input int i);
        oh = 4'b0001 << i;
    endfunction

    function automatic logic [34:0] mk_cfg(input logic ss, input logic [1:0] md,
                                           input logic [5:0] cl, input logic [9:0] sl,
                                           input logic [5:0] rl, input logic [9:0] dl);
        mk_cfg = {ss, md, cl, sl, rl, dl};
    endfunction

    function automatic logic [34:0] cfg_out();
        cfg_out = {spi_clk_ss, spi_mode, spi_cmd_length, spi_send_data_length,
                   spi_response_length, spi_receive_data_length};
    endfunction

    function automatic bit cond_met(input int sel);
        case (sel)
            W_GRANT: cond_met = (grant != 0);
            W_NOGNT: cond_met = (grant == 0);
            W_DONE:  cond_met = (done != 0);
            W_START: cond_met = spi_start;
            W_NOSTA: cond_met = !spi_start;
            W_IDLE:  cond_met = !arb_busy;
            default: cond_met = 1'b0;
        endcase
    endfunction

    task automatic wait_for(input int sel, input string what);
        int n;
        n = 0;
        while (!cond_met(sel) && n < WAIT_MAX) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (!cond_met(sel)) begin
            failures++;
            $display("FAIL wait_%s: not seen within %0d cycles", what, WAIT_MAX);
        end
    endtask

    // Master model: accepts spi_start after 3 cycles (busy), stays busy for
    // 5 cycles, then drops busy with a one-cycle valid. In hang mode it
    // never answers.
    int m_st;
    int m_cnt;
    initial begin
        busy_spi  = 1'b0;
        valid_spi = 1'b0;
        m_st      = 0;
        m_cnt     = 0;
        forever begin
            @(negedge clk);
            if (!rst_n || spi_rst) begin
                busy_spi  = 1'b0;
                valid_spi = 1'b0;
                m_st      = 0;
            end else begin
                case (m_st)
                    0: begin
                        valid_spi = 1'b0;
                        if (spi_start && !hang) begin
                            m_cnt = 0;
                            m_st  = 1;
                        end
                    end
                    1: begin
                        m_cnt++;
                        if (m_cnt == 3) begin
                            busy_spi = 1'b1;
                            m_cnt    = 0;
                            m_st     = 2;
                        end
                    end
                    default: begin
                        m_cnt++;
                        if (m_cnt == 5) begin
                            busy_spi  = 1'b0;
                            valid_spi = 1'b1;
                            m_st      = 0;
                        end
                    end
                endcase
            end
        end
    end

    // Scoreboard and invariants
    always @(negedge clk) begin
        sb_t e;
        if (rst_n) begin
            chk("inv_grant_onehot0", {63'd0, $onehot0(grant)}, 64'd1);
            chk("inv_done_in_grant", done & ~grant, 64'd0);
            chk("inv_start_and_rst", spi_start & spi_rst, 64'd0);
            if (done != 0) begin
                if (sb_q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL sb_unexpected_done: got done=%b, none expected", done);
                end else begin
                    e = sb_q.pop_front();
                    chk("sb_done_owner", done, oh(e.owner));
                    chk("sb_err", err, e.err);
                end
            end else begin
                chk("err_without_done", err, 64'd0);
            end
        end
    end

    initial begin
        int n;
        int hi;
        int rr_exp[5];

        cfg_tbl[0] = mk_cfg(1'b0, 2'b01, 6'd8,  10'd16,   6'd4,  10'd32);
        cfg_tbl[1] = mk_cfg(1'b1, 2'b11, 6'd16, 10'd0,    6'd0,  10'd512);
        cfg_tbl[2] = mk_cfg(1'b1, 2'b00, 6'd1,  10'd2,    6'd3,  10'd4);
        cfg_tbl[3] = mk_cfg(1'b0, 2'b10, 6'd40, 10'd1023, 6'd63, 10'd1);

        // {req, expected owner, expected err, master hangs}; pointer evolution
        // starting at 0: 3,0,1,1,0,2,1,3,1
        vecs[0] = '{4'b0100, 2, 1'b0, 1'b0};
        vecs[1] = '{4'b1111, 3, 1'b0, 1'b0};
        vecs[2] = '{4'b1111, 0, 1'b0, 1'b0};
        vecs[3] = '{4'b0001, 0, 1'b0, 1'b0};
        vecs[4] = '{4'b1001, 3, 1'b0, 1'b0};
        vecs[5] = '{4'b0110, 1, 1'b0, 1'b0};
        vecs[6] = '{4'b0011, 0, 1'b0, 1'b0};
        vecs[7] = '{4'b0100, 2, 1'b1, 1'b1};
        vecs[8] = '{4'b0011, 0, 1'b0, 1'b0};

        rst_n = 1'b0;
        req   = '0;
        hang  = 1'b0;
        for (int i = 0; i < NREQ; i++) cfg_flat[i*CFG_W +: CFG_W] = cfg_tbl[i];

        // Reset state
        repeat (3) @(negedge clk);
        chk("rst_grant", grant, 0);
        chk("rst_done", done, 0);
        chk("rst_err", err, 0);
        chk("rst_spi_start", spi_start, 0);
        chk("rst_spi_rst", spi_rst, 0);
        chk("rst_cfg", cfg_out(), 0);
        chk("rst_arb_busy", arb_busy, 0);
        rst_n = 1'b1;
        @(negedge clk);

        // All requests low: stay idle
        repeat (4) @(negedge clk);
        chk("idle_grant", grant, 0);
        chk("idle_busy", arb_busy, 0);

        // Vector table
        for (int v = 0; v < 9; v++) begin
            wait_for(W_IDLE, "idle");
            hang = vecs[v].hang;
            sb_q.push_back('{vecs[v].owner, vecs[v].err});
            req = vecs[v].req;
            @(negedge clk);
            chk($sformatf("v%0d_grant", v), grant, oh(vecs[v].owner));
            chk($sformatf("v%0d_cfg", v), cfg_out(), cfg_tbl[vecs[v].owner]);
            chk($sformatf("v%0d_arb_busy", v), arb_busy, 1);
            n = 0;
            while (!spi_start && n < WAIT_MAX) begin
                @(negedge clk);
                n++;
            end
            chk($sformatf("v%0d_settle_cycles", v), n, SETTLE);
            if (vecs[v].hang) begin
                hi = 0;
                while (spi_start && hi < WAIT_MAX) begin
                    hi++;
                    @(negedge clk);
                end
                chk("to_start_cycles", hi, TIMEOUT);
                chk("to_rst_rise", spi_rst, 1);
                hi = 0;
                while (spi_rst && hi < WAIT_MAX) begin
                    hi++;
                    @(negedge clk);
                end
                chk("to_rst_cycles", hi, 4);
                chk("to_done", done, oh(vecs[v].owner));
                chk("to_err", err, 1);
            end else begin
                wait_for(W_DONE, "done");
            end
            req  = '0;
            hang = 1'b0;
        end

        // Config isolation: requester 1 (mode 11), cfg changes mid-RUN
        wait_for(W_IDLE, "idle");
        sb_q.push_back('{1, 1'b0});
        req = 4'b0010;
        @(negedge clk);
        chk("iso_grant", grant, 4'b0010);
        chk("iso_mode", spi_mode, 2'b11);
        wait_for(W_START, "iso_start");
        wait_for(W_NOSTA, "iso_run");
        cfg_flat[1*CFG_W +: CFG_W] = mk_cfg(1'b0, 2'b00, 6'd2, 10'd3, 6'd4, 10'd5);
        n = 0;
        while (done == 0 && n < WAIT_MAX) begin
            chk("iso_mode_run", spi_mode, 2'b11);
            @(negedge clk);
            n++;
        end
        chk("iso_done", done, 4'b0010);
        chk("iso_cfg_finish", cfg_out(), cfg_tbl[1]);
        req = '0;
        wait_for(W_IDLE, "idle");
        chk("iso_mode_idle", spi_mode, 2'b11);
        cfg_flat[1*CFG_W +: CFG_W] = cfg_tbl[1];

        // Async reset during RUN (requester 2, pointer at 2)
        req = 4'b0100;
        @(negedge clk);
        chk("ar_grant", grant, 4'b0100);
        wait_for(W_START, "ar_start");
        wait_for(W_NOSTA, "ar_run");
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("ar_grant_low", grant, 0);
        chk("ar_start_low", spi_start, 0);
        chk("ar_rst_low", spi_rst, 0);
        chk("ar_done_low", done, 0);
        chk("ar_busy_low", arb_busy, 0);
        req = '0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("ar_idle_after", arb_busy, 0);

        // Round-robin with all requests held; pointer restarts at 0
        rr_exp = '{0, 1, 2, 3, 0};
        for (int k = 0; k < 5; k++) sb_q.push_back('{rr_exp[k], 1'b0});
        req = 4'b1111;
        for (int k = 0; k < 5; k++) begin
            wait_for(W_GRANT, "rr_grant");
            chk($sformatf("rr%0d_grant", k), grant, oh(rr_exp[k]));
            wait_for(W_DONE, "rr_done");
            if (k == 4) req = '0;
            @(negedge clk);
            chk($sformatf("rr%0d_gap", k), grant, 0);
        end

        // Starvation: req[0] held, req[3] joins mid-transaction (pointer 1)
        wait_for(W_IDLE, "idle");
        sb_q.push_back('{0, 1'b0});
        req = 4'b0001;
        @(negedge clk);
        chk("st_grant0", grant, 4'b0001);
        repeat (5) @(negedge clk);
        sb_q.push_back('{3, 1'b0});
        sb_q.push_back('{0, 1'b0});
        req = 4'b1001;
        wait_for(W_DONE, "st_done0");
        @(negedge clk);
        wait_for(W_GRANT, "st_grant3");
        chk("st_grant3", grant, 4'b1000);
        wait_for(W_DONE, "st_done3");
        req = 4'b0001;
        @(negedge clk);
        wait_for(W_GRANT, "st_regrant0");
        chk("st_regrant0", grant, 4'b0001);
        wait_for(W_DONE, "st_done0b");
        req = '0;
        wait_for(W_IDLE, "idle");
        repeat (3) @(negedge clk);
        chk("end_grant", grant, 0);
        chk("sb_empty", sb_q.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
